// File: rtl/data_trans_pkg.sv
// Shared types and constants for the data_trans round-robin frame arbiter.
package data_trans_pkg;
    localparam int DT_W  = 8;   // data_trans byte width
    localparam int GNT_W = 3;   // grant index width (up to 8 requesters)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_e;
endpackage

// File: rtl/data_trans_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at/after ptr_i, wrapping.
module rr_arbiter
    import data_trans_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [GNT_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_oh_o,
    output logic [GNT_W-1:0] gnt_idx_o,
    output logic             any_o
);
    always_comb begin
        int j;
        logic found;
        j         = 0;
        found     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found       = 1'b1;
                gnt_oh_o[j] = 1'b1;
                gnt_idx_o   = GNT_W'(j);
            end
        end
        any_o = |req_i;
    end
endmodule

// File: rtl/data_trans_arb.sv
// Round-robin frame arbiter/sequencer feeding one data_trans channel.
// Optional frame/abort statistics counters under DATA_TRANS_ARB_STATS_EN.
module data_trans_arb
    import data_trans_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [DT_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  tx_start,
    output logic                  tx_byte,
    output logic [DT_W-1:0]       tx_data,
    output logic [GNT_W-1:0]      grant_id,
    output logic                  busy,
    output logic                  err_underrun
`ifdef DATA_TRANS_ARB_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            abort_cnt
`endif
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_oh_q;
    logic [GNT_W-1:0] grant_q, rr_q;
    logic [GAP_W-1:0] gap_q;
    logic             first_q, tx_start_q, tx_byte_q, err_q;
    logic [DT_W-1:0]  tx_data_q;

    logic [N_REQ-1:0] arb_oh;
    logic [GNT_W-1:0] arb_idx, nxt_ptr;
    logic             arb_any, sel_valid, sel_last;
    logic [DT_W-1:0]  sel_data;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (rr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    // Owner's lane, selected by the registered one-hot grant.
    always_comb begin
        sel_valid = |(req_valid & gnt_oh_q);
        sel_last  = |(req_last & gnt_oh_q);
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt_oh_q[i]) sel_data = req_data[i*DT_W +: DT_W];
        nxt_ptr = (grant_q == GNT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end

    assign req_ready    = (state_q == SEND || state_q == DRAIN) ? gnt_oh_q : '0;
    assign busy         = (state_q != IDLE);
    assign tx_start     = tx_start_q;
    assign tx_byte      = tx_byte_q;
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_q;
    assign err_underrun = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_oh_q   <= '0;
            grant_q    <= '0;
            rr_q       <= '0;
            gap_q      <= '0;
            first_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_start_q <= 1'b0;
                    tx_byte_q  <= 1'b0;
                    if (arb_any) begin
                        grant_q  <= arb_idx;
                        gnt_oh_q <= arb_oh;
                        first_q  <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (sel_valid) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= sel_data;
                        tx_byte_q  <= first_q | sel_last;
                        first_q    <= 1'b0;
                        if (sel_last) begin
                            rr_q    <= nxt_ptr;
                            gap_q   <= GAP_INIT;
                            state_q <= GAP;
                        end
                    end else begin
                        // Underrun: abort, then swallow the rest of the frame.
                        tx_start_q <= 1'b0;
                        tx_byte_q  <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    tx_start_q <= 1'b0;
                    tx_byte_q  <= 1'b0;
                    if (sel_valid && sel_last) begin
                        rr_q    <= nxt_ptr;
                        gap_q   <= GAP_INIT;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    tx_start_q <= 1'b0;
                    tx_byte_q  <= 1'b0;
                    if (gap_q == '0) state_q <= IDLE;
                    else             gap_q   <= gap_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DATA_TRANS_ARB_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  abort_cnt_q;
    logic        frame_done, frame_abort;

    assign frame_done  = (state_q == SEND) && sel_valid && sel_last;
    assign frame_abort = (state_q == SEND) && !sel_valid;
    assign frame_cnt   = frame_cnt_q;
    assign abort_cnt   = abort_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (frame_abort && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_data_trans_arb.sv
// Directed bench for data_trans_arb: framing, round-robin, underrun drain, async reset.
module tb_data_trans_arb;
    logic        clk, reset;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        tx_start, tx_byte, busy, err_underrun;
    logic [7:0]  tx_data;
    logic [2:0]  grant_id;
`ifdef DATA_TRANS_ARB_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  abort_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    data_trans_arb #(.N_REQ(4), .GAP_CYCLES(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_byte      (tx_byte),
        .tx_data      (tx_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_underrun (err_underrun)
`ifdef DATA_TRANS_ARB_STATS_EN
        ,
        .frame_cnt    (frame_cnt),
        .abort_cnt    (abort_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] id, input logic v, input logic [7:0] d, input logic l);
        req_valid[id]           = v;
        req_data[int'(id)*8 +: 8] = d;
        req_last[id]            = l;
    endtask

    task automatic chk_tx(input string tag, input logic s, input logic b, input logic [7:0] d);
        chk({tag, ".start"}, 32'(tx_start), 32'(s));
        chk({tag, ".byte"},  32'(tx_byte),  32'(b));
        chk({tag, ".data"},  32'(tx_data),  32'(d));
    endtask

    task automatic chk_zero(input string tag);
        chk_tx(tag, 1'b0, 1'b0, 8'h00);
        chk({tag, ".grant"}, 32'(grant_id),     32'd0);
        chk({tag, ".busy"},  32'(busy),         32'd0);
        chk({tag, ".err"},   32'(err_underrun), 32'd0);
        chk({tag, ".ready"}, 32'(req_ready),    32'd0);
    endtask

    logic [7:0] f1 [5] = '{8'h35, 8'hAF, 8'hE6, 8'hE6, 8'h55};
    logic       b1 [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
`ifdef DATA_TRANS_ARB_STATS_EN
        chk("rst.frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst.abort_cnt", 32'(abort_cnt), 32'd0);
`endif
        #3 reset = 1'b0;

        // Five-byte frame from req0.
        set_req(2'd0, 1'b1, 8'h35, 1'b0);
        tick();
        chk("f1.grant", 32'(grant_id),  32'd0);
        chk("f1.ready", 32'(req_ready), 32'h1);
        chk("f1.busy",  32'(busy),      32'd1);
        for (int k = 0; k < 5; k++) begin
            set_req(2'd0, 1'b1, f1[k], (k == 4));
            tick();
            chk_tx($sformatf("f1.b%0d", k), 1'b1, b1[k], f1[k]);
        end
        set_req(2'd0, 1'b0, 8'h00, 1'b0);
        tick();
        chk_tx("f1.gap", 1'b0, 1'b0, 8'h55);
        chk("f1.idle", 32'(busy), 32'd0);

        // Fresh pointer: req0 and req2 together.
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        set_req(2'd0, 1'b1, 8'h11, 1'b0);
        set_req(2'd2, 1'b1, 8'hA5, 1'b1);
        tick();
        chk("rr.g0",    32'(grant_id),  32'd0);
        chk("rr.rdy0",  32'(req_ready), 32'h1);
        tick();
        chk_tx("rr.b0", 1'b1, 1'b1, 8'h11);
        set_req(2'd0, 1'b1, 8'h22, 1'b1);
        tick();
        chk_tx("rr.b1", 1'b1, 1'b1, 8'h22);
        set_req(2'd0, 1'b1, 8'h33, 1'b1);
        tick();
        chk("rr.gap", 32'(tx_start), 32'd0);
        tick();
        chk("rr.g2",   32'(grant_id),  32'd2);
        chk("rr.rdy2", 32'(req_ready), 32'h4);
        tick();
        chk_tx("single", 1'b1, 1'b1, 8'hA5);
        set_req(2'd2, 1'b0, 8'h00, 1'b0);
        tick();
        chk_tx("single.gap", 1'b0, 1'b0, 8'hA5);
        tick();
        chk("rr.wrap", 32'(grant_id), 32'd0);
        tick();
        chk_tx("rr.b2", 1'b1, 1'b1, 8'h33);
        set_req(2'd0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("rr.idle", 32'(busy), 32'd0);

        // Underrun on req1 after two of four bytes.
        set_req(2'd1, 1'b1, 8'h10, 1'b0);
        tick();
        chk("ur.grant", 32'(grant_id), 32'd1);
        tick();
        chk_tx("ur.b0", 1'b1, 1'b1, 8'h10);
        set_req(2'd1, 1'b1, 8'h20, 1'b0);
        tick();
        chk_tx("ur.b1", 1'b1, 1'b0, 8'h20);
        set_req(2'd1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("ur.err", 32'(err_underrun), 32'd1);
        chk_tx("ur.abort", 1'b0, 1'b0, 8'h20);
        chk("ur.busy", 32'(busy), 32'd1);
        set_req(2'd1, 1'b1, 8'h30, 1'b0);
        tick();
        chk("ur.err1", 32'(err_underrun), 32'd0);
        chk_tx("ur.drain", 1'b0, 1'b0, 8'h20);
        chk("ur.rdy", 32'(req_ready), 32'h2);
        set_req(2'd1, 1'b1, 8'h40, 1'b1);
        tick();
        chk_tx("ur.gap", 1'b0, 1'b0, 8'h20);
        chk("ur.gbusy", 32'(busy), 32'd1);
        set_req(2'd1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("ur.idle", 32'(busy), 32'd0);
`ifdef DATA_TRANS_ARB_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'd3);
        chk("abort_cnt", 32'(abort_cnt), 32'd1);
`endif

        // Reset during the third byte of a req3 frame.
        set_req(2'd3, 1'b1, 8'hC1, 1'b0);
        tick();
        chk("mr.grant", 32'(grant_id), 32'd3);
        tick();
        chk_tx("mr.b0", 1'b1, 1'b1, 8'hC1);
        set_req(2'd3, 1'b1, 8'hC2, 1'b0);
        tick();
        chk_tx("mr.b1", 1'b1, 1'b0, 8'hC2);
        set_req(2'd3, 1'b1, 8'hC3, 1'b0);
        #2 reset = 1'b1;
        #1 chk_zero("mr.rst");
        #1 reset = 1'b0;
        tick();
        chk("mr.regrant", 32'(grant_id),  32'd3);
        chk("mr.rdy",     32'(req_ready), 32'h8);
        set_req(2'd3, 1'b1, 8'hD0, 1'b1);
        tick();
        chk_tx("mr.b", 1'b1, 1'b1, 8'hD0);
        set_req(2'd3, 1'b0, 8'h00, 1'b0);
        tick();
        chk("mr.end", 32'(tx_start), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
